// File: rtl/dmem_responder.sv
// Byte-serial data-memory responder: accepts one load/store request, walks it
// byte by byte (big-endian), then holds a response until the requester takes it.
module dmem_responder #(
   parameter int MEM_BYTES = 32,
   parameter int ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic              req_size,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   input  logic [4:0]        dbg_addr,
   output logic [7:0]        dbg_byte
);

   localparam int IDX_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   logic [1:0]       r_state;
   logic             r_we;
   logic             r_size;
   logic [IDX_W-1:0] r_addr;
   logic [31:0]      r_wdata;
   logic [1:0]       r_k;
   logic [31:0]      r_rdata;
   logic             r_err;
   logic [7:0]       r_mem [MEM_BYTES];

   logic [ADDR_W:0]  w_n;
   logic [ADDR_W:0]  w_end;
   logic             w_in_range;
   logic [IDX_W-1:0] w_idx;
   logic [7:0]       w_rbyte;
   logic [31:0]      w_wshift;
   logic [7:0]       w_wbyte;
   logic             w_last;

   // Range check is done one bit wider than the address so it can never wrap.
   assign w_n        = req_size ? (ADDR_W+1)'(4) : (ADDR_W+1)'(1);
   assign w_end      = {1'b0, req_addr} + w_n;
   assign w_in_range = (w_end <= (ADDR_W+1)'(MEM_BYTES));

   assign w_idx    = r_addr + IDX_W'(r_k);
   assign w_rbyte  = r_mem[w_idx];
   assign w_wshift = r_wdata << {r_k, 3'b000};
   assign w_wbyte  = r_size ? w_wshift[31:24] : r_wdata[7:0];
   assign w_last   = r_size ? (r_k == 2'd3) : 1'b1;

   assign req_ready = (r_state == S_IDLE);
   assign rsp_valid = (r_state == S_RESP);
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;
   assign dbg_byte  = r_mem[dbg_addr];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_k     <= 2'd0;
         r_rdata <= 32'd0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_we    <= req_we;
                  r_size  <= req_size;
                  r_addr  <= req_addr[IDX_W-1:0];
                  r_wdata <= req_wdata;
                  r_k     <= 2'd0;
                  r_rdata <= 32'd0;
                  r_err   <= !w_in_range;
                  r_state <= w_in_range ? S_ACCESS : S_RESP;
               end
            end
            S_ACCESS: begin
               if (!r_we) begin
                  r_rdata <= r_size ? {r_rdata[23:0], w_rbyte}
                                    : {{24{w_rbyte[7]}}, w_rbyte};
               end
               r_k <= r_k + 2'd1;
               if (w_last) r_state <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_state <= S_IDLE;
                  r_rdata <= 32'd0;
                  r_err   <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // NOTE: the memory array has no reset on purpose; its contents survive reset,
   // and a reset edge suppresses the write so an aborted store stops cleanly.
   always_ff @(posedge clk) begin
      if (!reset && (r_state == S_ACCESS) && r_we) begin
         r_mem[w_idx] <= w_wbyte;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random traffic
// compared against a byte-array model of the memory.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic        req_size = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [4:0]  dbg_addr = '0;
   logic [7:0]  dbg_byte;

   int checks = 0;
   int failures = 0;

   logic [7:0]  model_mem [32];
   logic [31:0] exp_rdata;
   logic        exp_err;
   int          exp_lat;

   dmem_responder #(.MEM_BYTES(32), .ADDR_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_size  (req_size),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .dbg_addr  (dbg_addr),
      .dbg_byte  (dbg_byte)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic peek(input int a);
      dbg_addr = 5'(a);
      #1;
      check($sformatf("dbg_byte[%0d]", a), 32'(dbg_byte), 32'(model_mem[a]));
   endtask

   // Drive a request, take the acceptance edge and work out the expected response.
   task automatic issue(input logic we, input logic size, input logic [31:0] addr,
                        input logic [31:0] wdata);
      int n;
      logic [32:0] fin;
      int a;
      n = size ? 4 : 1;
      req_valid = 1'b1;
      req_we    = we;
      req_size  = size;
      req_addr  = addr;
      req_wdata = wdata;
      check("req_ready_before_issue", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      req_we    = 1'($urandom);
      req_size  = 1'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      fin = {1'b0, addr} + 33'(n);
      if (fin > 33'd32) begin
         exp_err = 1'b1; exp_rdata = 32'd0; exp_lat = 0;
      end else begin
         a = int'(addr);
         exp_err = 1'b0; exp_lat = n; exp_rdata = 32'd0;
         if (we) begin
            if (size) for (int i = 0; i < 4; i++) model_mem[a+i] = wdata[31-8*i -: 8];
            else model_mem[a] = wdata[7:0];
         end else if (size) begin
            exp_rdata = {model_mem[a], model_mem[a+1], model_mem[a+2], model_mem[a+3]};
         end else begin
            exp_rdata = {{24{model_mem[a][7]}}, model_mem[a]};
         end
      end
   endtask

   task automatic wait_rsp(input string tag);
      int lat;
      lat = 0;
      while (!rsp_valid && lat < 10) begin
         tick();
         lat++;
      end
      check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
      check({tag, "_rdata"}, rsp_rdata, exp_rdata);
   endtask

   task automatic finish_rsp(input string tag);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
      check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
   endtask

   task automatic do_req(input string tag, input logic we, input logic size,
                         input logic [31:0] addr, input logic [31:0] wdata);
      issue(we, size, addr, wdata);
      wait_rsp(tag);
      finish_rsp(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] held_rdata;
      logic        we;
      logic        size;
      logic [31:0] addr;

      // Reset held for two cycles.
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check("reset_req_ready", 32'(req_ready), 32'd1);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_err", 32'(rsp_err), 32'd0);
      check("reset_rsp_rdata", rsp_rdata, 32'd0);

      // Fill the whole memory with known random data.
      for (int i = 0; i < 8; i++) do_req("init", 1'b1, 1'b1, 32'(4*i), $urandom);

      // Big-endian word store and load.
      do_req("word_st4", 1'b1, 1'b1, 32'd4, 32'h11223344);
      dbg_addr = 5'd4; #1; check("dbg4_const", 32'(dbg_byte), 32'h11);
      dbg_addr = 5'd5; #1; check("dbg5_const", 32'(dbg_byte), 32'h22);
      dbg_addr = 5'd6; #1; check("dbg6_const", 32'(dbg_byte), 32'h33);
      dbg_addr = 5'd7; #1; check("dbg7_const", 32'(dbg_byte), 32'h44);
      do_req("word_ld4", 1'b0, 1'b1, 32'd4, 32'd0);
      check("word_ld4_const", exp_rdata, 32'h11223344);

      // Byte store/load with sign extension.
      do_req("byte_st8", 1'b1, 1'b0, 32'd8, 32'hDEADBE80);
      issue(1'b0, 1'b0, 32'd8, 32'd0);
      wait_rsp("byte_ld8");
      check("byte_ld8_const", rsp_rdata, 32'hFFFFFF80);
      finish_rsp("byte_ld8");
      issue(1'b0, 1'b0, 32'd7, 32'd0);
      wait_rsp("byte_ld7");
      check("byte_ld7_const", rsp_rdata, 32'h00000044);
      finish_rsp("byte_ld7");

      // Range boundaries, including an address that would wrap.
      do_req("oor_word29", 1'b1, 1'b1, 32'd29, 32'hCAFEF00D);
      do_req("oor_byte32", 1'b0, 1'b0, 32'd32, 32'd0);
      do_req("oor_wrap", 1'b1, 1'b1, 32'hFFFFFFFE, 32'h01020304);
      for (int a = 28; a < 32; a++) peek(a);
      do_req("edge_word28", 1'b0, 1'b1, 32'd28, 32'd0);
      do_req("edge_byte31", 1'b0, 1'b0, 32'd31, 32'd0);

      // Response back-pressure with a competing request.
      issue(1'b0, 1'b1, 32'd4, 32'd0);
      wait_rsp("stall_ld");
      held_rdata = rsp_rdata;
      req_valid = 1'b1; req_we = 1'b1; req_size = 1'b0;
      req_addr = 32'd0; req_wdata = 32'h0000005A;
      for (int c = 0; c < 5; c++) begin
         tick();
         check("stall_valid", 32'(rsp_valid), 32'd1);
         check("stall_rdata", rsp_rdata, exp_rdata);
         check("stall_rdata_held", rsp_rdata, held_rdata);
         check("stall_err", 32'(rsp_err), 32'd0);
         check("stall_req_ready", 32'(req_ready), 32'd0);
      end
      finish_rsp("stall");
      req_valid = 1'b0;
      tick();
      check("post_stall_idle", 32'(rsp_valid), 32'd0);
      peek(0);

      // Random traffic.
      for (int t = 0; t < 30; t++) begin
         we   = 1'($urandom);
         size = 1'($urandom);
         addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 35));
         do_req($sformatf("rand%0d", t), we, size, addr, $urandom);
         peek(int'($urandom_range(0, 31)));
      end

      // Reset after two ACCESS edges of a word store aborts it.
      req_valid = 1'b1; req_we = 1'b1; req_size = 1'b1;
      req_addr = 32'd12; req_wdata = 32'hAABBCCDD;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      model_mem[12] = 8'hAA;
      model_mem[13] = 8'hBB;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_req_ready", 32'(req_ready), 32'd1);
      check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      for (int c = 0; c < 4; c++) begin
         tick();
         check("abort_no_rsp", 32'(rsp_valid), 32'd0);
      end
      for (int a = 12; a < 16; a++) peek(a);
      dbg_addr = 5'd12; #1; check("abort_mem12_const", 32'(dbg_byte), 32'hAA);
      dbg_addr = 5'd13; #1; check("abort_mem13_const", 32'(dbg_byte), 32'hBB);
      do_req("after_abort", 1'b0, 1'b1, 32'd12, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
